rr_word_mux: RTL and testbench

Parametrised N-channel, W-bit word selector with per-channel valid/ready handshaking, a registered output stage and two selection modes: fixed (external select) and round-robin arbitration. It sits where the 16:1 byte muxes of the datapath feed a consumer that can stall. It replaces a purely combinational select with a flow-controlled, one-cycle-latency stage that never drops or duplicates a word.

---
 rtl/rr_word_mux_if.sv | 27 ++
 rtl/rr_word_mux.sv | 83 ++++++++
 tb/tb_rr_word_mux.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/rr_word_mux_if.sv
// Handshake bundle for rr_word_mux: N-channel word inputs and one
// registered output.
interface rr_word_mux_if #(
    parameter int WIDTH = 8,
    parameter int N     = 16,
    parameter int SELW  = $clog2(N)
);
    logic [N*WIDTH-1:0] data_in;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_ch;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output data_in, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  data_in, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/rr_word_mux.sv
// N-channel word selector with fixed or round-robin grant and a
// flow-controlled, one-cycle output register.
module rr_word_mux #(
    parameter int WIDTH = 8,
    parameter int N     = 16,
    parameter int SELW  = $clog2(N)
) (
    input logic          clk,
    input logic          rst_n,
    rr_word_mux_if.slave bus
);
    logic [N-1:0]     grant;
    logic [SELW-1:0]  gidx;
    logic             gnt_any;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;

    // modulo-N add keeps the pointer legal for non-power-of-two N
    function automatic logic [SELW-1:0] wrap_add(
        input logic [SELW-1:0] a,
        input int              b
    );
        return SELW'((int'(a) + b) % N);
    endfunction

    always_comb begin
        gidx    = '0;
        gnt_any = 1'b0;
        if (!bus.mode) begin
            if (int'(bus.sel) < N) begin
                if (bus.in_valid[bus.sel]) begin
                    gidx    = bus.sel;
                    gnt_any = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!gnt_any && bus.in_valid[wrap_add(ptr_q, i)]) begin
                    gidx    = wrap_add(ptr_q, i);
                    gnt_any = 1'b1;
                end
            end
        end
        grant = '0;
        if (gnt_any) grant[gidx] = 1'b1;

        load        = !out_valid_q || bus.out_ready;
        xfer        = load && gnt_any;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d = bus.data_in[int'(gidx)*WIDTH +: WIDTH];
            out_ch_d   = gidx;
        end
        if (load) out_valid_d = xfer;
        if (xfer && bus.mode) ptr_d = wrap_add(gidx, 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = (load && rst_n) ? grant : '0;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_word_mux.sv
// Scoreboard bench for rr_word_mux: a 16-channel instance driven
// against a reference model and a 12-channel instance for range/wrap cases.
module tb_rr_word_mux;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_word_mux_if #(.WIDTH(8), .N(16)) b16 ();
    rr_word_mux_if #(.WIDTH(8), .N(12)) b12 ();

    rr_word_mux #(.WIDTH(8), .N(16)) u16 (
        .clk(clk), .rst_n(rst_n), .bus(b16)
    );
    rr_word_mux #(.WIDTH(8), .N(12)) u12 (
        .clk(clk), .rst_n(rst_n), .bus(b12)
    );

    typedef struct {
        int         ch;
        logic [7:0] d;
    } exp_t;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] word [16];
    exp_t       sb [$];
    bit         m_valid;
    int         m_ptr;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant(input bit m, input int s,
                                       input logic [15:0] v, input int p);
        if (!m) return (s < 16 && v[s]) ? s : -1;
        for (int i = 0; i < 16; i++)
            if (v[(p + i) % 16]) return (p + i) % 16;
        return -1;
    endfunction

    task automatic drive16(input bit m, input logic [3:0] s,
                           input logic [15:0] v, input bit rdy);
        b16.mode      = m;
        b16.sel       = s;
        b16.in_valid  = v;
        b16.out_ready = rdy;
        for (int k = 0; k < 16; k++) b16.data_in[k*8 +: 8] = word[k];
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle16;
        int   g;
        bit   ld;
        exp_t e;
        #1;
        g  = model_grant(b16.mode, int'(b16.sel), b16.in_valid, m_ptr);
        ld = !m_valid || b16.out_ready;
        check("in_ready", b16.in_ready,
              (ld && g >= 0) ? (64'd1 << g) : 64'd0);
        check("out_valid", b16.out_valid, m_valid);
        if (m_valid) begin
            check("out_ch", b16.out_ch, sb[0].ch);
            check("out_data", b16.out_data, sb[0].d);
            if (b16.out_ready) void'(sb.pop_front());
        end
        if (ld) begin
            if (g >= 0) begin
                e.ch = g;
                e.d  = word[g];
                sb.push_back(e);
                m_valid = 1'b1;
                if (b16.mode) m_ptr = (g + 1) % 16;
            end else begin
                m_valid = 1'b0;
            end
        end
        step();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) word[k] = 8'h10 + 8'(k);
        m_valid = 1'b0;
        m_ptr   = 0;
        rst_n   = 1'b0;
        drive16(1'b1, 4'd0, 16'hFFFF, 1'b1);
        b12.mode      = 1'b1;
        b12.sel       = 4'd0;
        b12.in_valid  = 12'hFFF;
        b12.out_ready = 1'b1;
        for (int k = 0; k < 12; k++) b12.data_in[k*8 +: 8] = word[k];
        #1;
        check("rst_out_valid", b16.out_valid, 0);
        check("rst_out_data", b16.out_data, 0);
        check("rst_out_ch", b16.out_ch, 0);
        check("rst_in_ready", b16.in_ready, 0);
        check("rst_in_ready12", b12.in_ready, 0);
        step();
        step();
        drive16(1'b0, 4'd0, 16'h0000, 1'b1);
        b12.mode     = 1'b0;
        b12.sel      = 4'd13;
        b12.in_valid = 12'hFFF;
        rst_n        = 1'b1;

        // 12-channel instance: out-of-range select and wrap at 11
        #1 check("n12_sel13_rdy", b12.in_ready, 0);
        step();
        #1 check("n12_sel13_ov", b12.out_valid, 0);
        b12.sel = 4'd11;
        #1 check("n12_sel11_rdy", b12.in_ready, 12'h800);
        step();
        #1;
        check("n12_sel11_ov", b12.out_valid, 1);
        check("n12_sel11_ch", b12.out_ch, 11);
        check("n12_sel11_d", b12.out_data, 8'h1B);
        b12.mode     = 1'b1;
        b12.in_valid = 12'h808;
        #1 check("n12_rr_rdy0", b12.in_ready, 12'h008);
        step();
        #1;
        check("n12_rr_ch0", b12.out_ch, 3);
        check("n12_rr_rdy1", b12.in_ready, 12'h800);
        step();
        #1;
        check("n12_rr_ch1", b12.out_ch, 11);
        check("n12_rr_rdy2", b12.in_ready, 12'h008);
        step();
        #1 check("n12_rr_ch2", b12.out_ch, 3);
        b12.in_valid = 12'h000;
        step();

        // fixed select of channel 5
        word[5] = 8'hA5;
        drive16(1'b0, 4'd5, 16'h0020, 1'b1);
        cycle16();
        drive16(1'b0, 4'd5, 16'h0000, 1'b1);
        cycle16();
        word[5] = 8'h15;

        // round-robin over all channels with wrap
        drive16(1'b1, 4'd0, 16'hFFFF, 1'b1);
        repeat (18) cycle16();
        drive16(1'b1, 4'd0, 16'h0000, 1'b1);
        cycle16();

        // bring ptr to 0 via channel 15, then alternate 0/15
        drive16(1'b1, 4'd0, 16'h8000, 1'b1);
        cycle16();
        drive16(1'b1, 4'd0, 16'h8001, 1'b1);
        repeat (4) cycle16();
        drive16(1'b1, 4'd0, 16'h0000, 1'b1);
        cycle16();

        // backpressure then release
        drive16(1'b1, 4'd0, 16'hFFFF, 1'b1);
        cycle16();
        drive16(1'b1, 4'd0, 16'hFFFF, 1'b0);
        repeat (3) cycle16();
        drive16(1'b1, 4'd0, 16'hFFFF, 1'b1);
        cycle16();
        cycle16();
        drive16(1'b1, 4'd0, 16'h0000, 1'b1);
        cycle16();

        // valid drops while stalled: nothing may be latched
        drive16(1'b1, 4'd0, 16'hFFFF, 1'b1);
        cycle16();
        drive16(1'b1, 4'd0, 16'hFFFF, 1'b0);
        cycle16();
        drive16(1'b1, 4'd0, 16'h0000, 1'b0);
        cycle16();
        drive16(1'b1, 4'd0, 16'h0000, 1'b1);
        cycle16();
        cycle16();

        // fixed-mode transfer with ptr away from zero leaves ptr alone
        drive16(1'b1, 4'd0, 16'h0040, 1'b1);
        cycle16();
        drive16(1'b0, 4'd9, 16'h0200, 1'b1);
        cycle16();
        drive16(1'b1, 4'd0, 16'h0081, 1'b1);
        cycle16();
        drive16(1'b1, 4'd0, 16'h0000, 1'b1);
        cycle16();

        // asynchronous reset mid-stream
        drive16(1'b1, 4'd0, 16'hFFFF, 1'b1);
        repeat (3) cycle16();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", b16.out_valid, 0);
        check("arst_out_data", b16.out_data, 0);
        check("arst_out_ch", b16.out_ch, 0);
        check("arst_in_ready", b16.in_ready, 0);
        sb.delete();
        m_valid = 1'b0;
        m_ptr   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle16();
        check("arst_restart_ch", b16.out_ch, 0);
        cycle16();
        drive16(1'b1, 4'd0, 16'h0000, 1'b1);
        cycle16();
        cycle16();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
